match_event_logger: RTL and testbench

//  Downstream consumer of the 2-bit-symbol Mealy sequence detector's 1-bit

---
 rtl/match_event_logger.sv | 117 +++++++++++
 tb/tb_match_event_logger.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/match_event_logger.sv
// Timestamps rising edges of a detector's match output and queues them in a small FIFO.
// Optional build macro MATCH_IRQ_EN adds a registered level/overflow interrupt output.
module match_event_logger #(
  parameter int unsigned TS_W       = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned IRQ_THRESH = 2,
  localparam int unsigned LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             match_in,
  input  logic             clr,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [TS_W-1:0]  evt_ts,
  output logic [CNT_W-1:0] evt_count,
  output logic [LVL_W-1:0] fifo_level,
`ifdef MATCH_IRQ_EN
  output logic             overflow,
  output logic             irq
`else
  output logic             overflow
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Parameter sanity, resolved at elaboration
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if ((IRQ_THRESH < 1) || (IRQ_THRESH > DEPTH)) begin : g_bad_thresh
    $error("IRQ_THRESH must be in 1..DEPTH");
  end

  logic [TS_W-1:0]  ts_cnt;
  logic             match_q;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [LVL_W-1:0] level_n;
  logic [CNT_W-1:0] count_n;
  logic             overflow_n;
  logic [TS_W-1:0]  head_n;
  logic [TS_W-1:0]  mem [DEPTH];

  logic event_c, pop_c, full_c, push_c;

  assign event_c = match_in & ~match_q;
  assign full_c  = (fifo_level == LVL_W'(DEPTH));
  assign pop_c   = (fifo_level != '0) & evt_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign push_c  = event_c & (~full_c | pop_c);

  always_comb begin
    rd_ptr_n   = rd_ptr;
    wr_ptr_n   = wr_ptr;
    level_n    = fifo_level;
    count_n    = evt_count;
    overflow_n = overflow;
    head_n     = '0;
    if (clr) begin
      rd_ptr_n   = '0;
      wr_ptr_n   = '0;
      level_n    = '0;
      count_n    = '0;
      overflow_n = 1'b0;
    end else begin
      if (push_c) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr_n = rd_ptr + PTR_W'(1);
      level_n = fifo_level + LVL_W'(push_c) - LVL_W'(pop_c);
      if (event_c && (evt_count != {CNT_W{1'b1}})) count_n = evt_count + CNT_W'(1);
      if (event_c && !push_c) overflow_n = 1'b1;
    end
    // Next head: the entry being written this edge if it lands at the new read slot
    if (level_n != '0) begin
      if (push_c && !clr && (wr_ptr == rd_ptr_n)) head_n = ts_cnt;
      else                                        head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt     <= '0;
      match_q    <= 1'b1;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      evt_count  <= '0;
      overflow   <= 1'b0;
      evt_valid  <= 1'b0;
      evt_ts     <= '0;
    end else begin
      ts_cnt     <= ts_cnt + TS_W'(1);
      match_q    <= match_in;
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      fifo_level <= level_n;
      evt_count  <= count_n;
      overflow   <= overflow_n;
      evt_valid  <= (level_n != '0);
      evt_ts     <= head_n;
    end
  end

  // Entry storage; contents are only meaningful under the level count
  always_ff @(posedge clk) begin
    if (!clr && push_c) mem[wr_ptr] <= ts_cnt;
  end

`ifdef MATCH_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= (level_n >= LVL_W'(IRQ_THRESH)) | overflow_n;
  end
`endif

endmodule

// File: tb/tb_match_event_logger.sv
// Directed bench for match_event_logger: default instance plus a CNT_W=3 instance
// sharing the same stimulus for the saturation check.
module tb_match_event_logger;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       match_in = 1'b0;
  logic       clr = 1'b0;
  logic       evt_ready = 1'b0;

  logic       evt_valid, overflow;
  logic [7:0] evt_ts, evt_count;
  logic [2:0] fifo_level;
  logic       d2_valid, d2_overflow;
  logic [7:0] d2_ts;
  logic [2:0] d2_count;
  logic [2:0] d2_level;
`ifdef MATCH_IRQ_EN
  logic       irq, d2_irq;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  tb_ts = '0;

  always #5 clk = ~clk;

  match_event_logger dut (
    .clk(clk), .rst(rst), .match_in(match_in), .clr(clr), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_ts(evt_ts), .evt_count(evt_count),
    .fifo_level(fifo_level),
`ifdef MATCH_IRQ_EN
    .overflow(overflow), .irq(irq)
`else
    .overflow(overflow)
`endif
  );

  match_event_logger #(.CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .match_in(match_in), .clr(clr), .evt_ready(evt_ready),
    .evt_valid(d2_valid), .evt_ts(d2_ts), .evt_count(d2_count),
    .fifo_level(d2_level),
`ifdef MATCH_IRQ_EN
    .overflow(d2_overflow), .irq(d2_irq)
`else
    .overflow(d2_overflow)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; tb_ts tracks the DUT timestamp value held before the next edge
  task automatic tick();
    @(posedge clk);
    tb_ts = tb_ts + 8'd1;
    #1;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without any clock edge
  task automatic do_reset(input logic hold_match);
    @(posedge clk);
    #1;
    match_in  = hold_match;
    evt_ready = 1'b0;
    clr       = 1'b0;
    rst       = 1'b0;
    #2;
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_count", 32'(evt_count), 0);
    check("rst_ts",    32'(evt_ts), 0);
    check("rst_ovf",   32'(overflow), 0);
`ifdef MATCH_IRQ_EN
    check("rst_irq",   32'(irq), 0);
`endif
    rst   = 1'b1;
    tb_ts = '0;
  endtask

  // Low for at least one edge, then high on the edge whose pre-edge timestamp is t
  task automatic pulse_at(input logic [7:0] t);
    match_in = 1'b0;
    tick();
    while (tb_ts != t) tick();
    match_in = 1'b1;
    tick();
    match_in = 1'b0;
  endtask

  task automatic fill_3_7_11_15();
    pulse_at(8'd3);
    pulse_at(8'd7);
    pulse_at(8'd11);
    pulse_at(8'd15);
  endtask

  initial begin
    // 1: match held through reset release is not an event
    do_reset(1'b1);
    tick(); tick();
    check("t1_valid_held", 32'(evt_valid), 0);
    check("t1_count_held", 32'(evt_count), 0);
    match_in = 1'b0; tick();
    match_in = 1'b1; tick();
    check("t1_valid", 32'(evt_valid), 1);
    check("t1_count", 32'(evt_count), 1);
    check("t1_ts",    32'(evt_ts), 3);

    // 2: fill to four, then drain in order
    do_reset(1'b0);
    fill_3_7_11_15();
    check("t2_level", 32'(fifo_level), 4);
    check("t2_valid", 32'(evt_valid), 1);
    check("t2_head",  32'(evt_ts), 3);
    evt_ready = 1'b1;
    tick(); check("t2_rd7",  32'(evt_ts), 7);
    tick(); check("t2_rd11", 32'(evt_ts), 11);
    tick(); check("t2_rd15", 32'(evt_ts), 15);
    tick(); check("t2_empty", 32'(evt_valid), 0);
    check("t2_empty_ts", 32'(evt_ts), 0);
    tick(); check("t2_ready_idle", 32'(fifo_level), 0);
    evt_ready = 1'b0;

    // 3: overflow on a fifth event while full
    do_reset(1'b0);
    fill_3_7_11_15();
    pulse_at(8'd19);
    check("t3_ovf",   32'(overflow), 1);
    check("t3_level", 32'(fifo_level), 4);
    check("t3_count", 32'(evt_count), 5);
    check("t3_head",  32'(evt_ts), 3);
    evt_ready = 1'b1;
    repeat (4) tick();
    check("t3_drained", 32'(evt_valid), 0);
    check("t3_ovf_sticky", 32'(overflow), 1);
    evt_ready = 1'b0;

    // 4: full with simultaneous pop and push
    do_reset(1'b0);
    fill_3_7_11_15();
    match_in = 1'b0;
    while (tb_ts != 8'd20) tick();
    match_in  = 1'b1;
    evt_ready = 1'b1;
    tick();
    match_in = 1'b0;
    check("t4_level", 32'(fifo_level), 4);
    check("t4_ovf",   32'(overflow), 0);
    check("t4_head",  32'(evt_ts), 7);
    tick(); check("t4_rd11", 32'(evt_ts), 11);
    tick(); check("t4_rd15", 32'(evt_ts), 15);
    tick(); check("t4_rd20", 32'(evt_ts), 20);
    tick(); check("t4_empty", 32'(evt_valid), 0);
    evt_ready = 1'b0;

    // 5: timestamp wrap and counter saturation on the narrow instance
    do_reset(1'b0);
    pulse_at(8'd254);
    pulse_at(8'd1);
    check("t5_head254", 32'(evt_ts), 254);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("t5_head1", 32'(evt_ts), 1);
    for (int i = 0; i < 7; i++) pulse_at(tb_ts + 8'd1);
    check("t5_count9",   32'(evt_count), 9);
    check("t5_sat_cnt3", 32'(d2_count), 7);

    // 6: clear wins over a coincident event
    do_reset(1'b0);
    pulse_at(8'd3);
    pulse_at(8'd6);
    check("t6_level2", 32'(fifo_level), 2);
`ifdef MATCH_IRQ_EN
    check("t6_irq_on", 32'(irq), 1);
`endif
    match_in = 1'b0; tick();
    match_in = 1'b1; clr = 1'b1; tick();
    clr = 1'b0;
    check("t6_level", 32'(fifo_level), 0);
    check("t6_count", 32'(evt_count), 0);
    check("t6_ovf",   32'(overflow), 0);
    check("t6_valid", 32'(evt_valid), 0);
`ifdef MATCH_IRQ_EN
    check("t6_irq_off", 32'(irq), 0);
`endif
    tick();
    check("t6_held_no_evt", 32'(evt_count), 0);
    match_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
